alu_result_trace_fifo: RTL and testbench

- Downstream consumer of the CPU core's `alu_result` and `stat` outputs.
- Captures each result/status pair when the core asserts a capture strobe. Entries are stored in order in a small FIFO.
- Entries drain to a trace or debug sink over a valid/ready handshake.
- Lets the bench, or a later UART/debug port, read back every ALU result without sampling the core on exact cycles.

---
 rtl/alu_result_trace_fifo.sv | 123 ++++++++++++
 tb/tb_alu_result_trace_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_trace_fifo.sv
// ALU result/status trace FIFO with saturating drop counter.
// Optional macro ALU_TRACE_DEDUP_EN suppresses repeats of the last accepted capture.
module alu_result_trace_fifo #(
    parameter int DATA_W = 8,
    parameter int STAT_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_valid,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic [STAT_W-1:0]        stat,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [STAT_W-1:0]        out_stat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int W     = STAT_W + DATA_W;

    localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   C_ONE   = 1;
    localparam logic [PTR_W-1:0] P_ONE   = 1;
    localparam logic [CNT_W-1:0] D_ONE   = 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [W-1:0] cap_word;
    logic [W-1:0] head_word;
    logic         eligible;
    logic         pop;
    logic         push;
    logic         drop;

    assign cap_word = {stat, alu_result};

`ifdef ALU_TRACE_DEDUP_EN
    logic [W-1:0] last_q;
    logic         last_vld_q;
    logic         dup;

    assign dup      = last_vld_q && (last_q == cap_word);
    assign eligible = cap_valid && !dup;

    // Remember the most recent capture that actually entered the FIFO
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= cap_word;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign eligible = cap_valid;
`endif

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready;
    assign push  = eligible && (!full || pop);
    assign drop  = eligible && full && !pop;

    // Next-state for pointers, occupancy and drop counter; flush wins
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            drop_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + P_ONE;
            if (pop)  rptr_d = rptr_q + P_ONE;
            if (push && !pop) count_d = count_q + C_ONE;
            if (pop && !push) count_d = count_q - C_ONE;
            if (drop && (drop_q != '1)) drop_d = drop_q + D_ONE;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Storage write; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) mem_q[wptr_q] <= cap_word;
    end

    assign head_word  = empty ? '0 : mem_q[rptr_q];
    assign out_valid  = !empty;
    assign out_result = head_word[DATA_W-1:0];
    assign out_stat   = head_word[W-1:DATA_W];
    assign count      = count_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_alu_result_trace_fifo.sv
// Directed self-checking bench for alu_result_trace_fifo.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_alu_result_trace_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       cap_valid;
    logic [7:0] alu_result;
    logic [3:0] stat;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_stat;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];

    alu_result_trace_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .cap_valid  (cap_valid),
        .alu_result (alu_result),
        .stat       (stat),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_stat   (out_stat),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cap(input logic [7:0] r, input logic [3:0] s);
        cap_valid  = 1'b1;
        alu_result = r;
        stat       = s;
        tick();
        cap_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cap_valid = 1'b0; alu_result = '0; stat = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_stat", out_stat, 0);
        chk("rst_drop", drop_cnt, 0);

        // single capture, one-cycle latency
        cap(8'h3C, 4'h5);
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, 8'h3C);
        chk("t1_stat", out_stat, 4'h5);
        chk("t1_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_empty", empty, 1);

        // fill and overflow
        for (int i = 1; i <= 10; i++) begin
            cap(i[7:0], 4'h0);
            if (i == 8) chk("t2_full8", full, 1);
        end
        chk("t2_full", full, 1);
        chk("t2_count", count, 8);
        chk("t2_drop", drop_cnt, 2);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_drain", out_result, i);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("t2_empty", empty, 1);

        // simultaneous push and pop while full
        for (int i = 0; i < 8; i++) cap(8'h41 + i[7:0], 4'h0);
        chk("t3_full", full, 1);
        out_ready = 1'b1;
        cap(8'h77, 4'h2);
        out_ready = 1'b0;
        chk("t3_count", count, 8);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_head", out_result, 8'h42);
        for (int i = 0; i < 7; i++) begin
            chk("t3_drain", out_result, 8'h42 + i);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("t3_last", out_result, 8'h77);
        chk("t3_last_stat", out_stat, 4'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_empty", empty, 1);

        // backpressure stream with toggling ready
        begin
            int sent = 0;
            int cyc  = 0;
            logic rdy;
            while ((sent < 20 || mq.size() != 0) && cyc < 200) begin
                rdy = cyc[0];
                if (mq.size() != 0) begin
                    chk("t4_valid", out_valid, 1);
                    chk("t4_head", out_result, mq[0]);
                end else begin
                    chk("t4_empty", out_valid, 0);
                end
                chk("t4_count", count, mq.size());
                out_ready = rdy;
                cap_valid = (sent < 20) && ((mq.size() < 8) || rdy);
                alu_result = 8'h80 + sent[7:0];
                stat = sent[3:0];
                if (rdy && mq.size() != 0) void'(mq.pop_front());
                if (cap_valid) begin
                    mq.push_back(alu_result);
                    sent++;
                end
                tick();
                cyc++;
            end
            cap_valid = 1'b0;
            out_ready = 1'b0;
            chk("t4_bound", cyc < 200, 1);
            chk("t4_done_empty", empty, 1);
            chk("t4_drop", drop_cnt, 2);
        end

        // flush mid-operation
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 11; i++) cap(8'hA0 + i[7:0], 4'h3);
            out_ready = 1'b1;
            tick(); tick(); tick();
            out_ready = 1'b0;
            chk("t5_count5", count, 5);
            chk("t5_drop3", drop_cnt, 3);
            chk("t5_head", out_result, 8'hA3);
            if (k == 0) flush = 1'b1;
            else rst = 1'b1;
            cap(8'hEE, 4'hE);
            flush = 1'b0;
            rst = 1'b0;
            chk(k == 0 ? "t5_flush_count" : "t5_rst_count", count, 0);
            chk(k == 0 ? "t5_flush_drop" : "t5_rst_drop", drop_cnt, 0);
            chk(k == 0 ? "t5_flush_valid" : "t5_rst_valid", out_valid, 0);
            chk(k == 0 ? "t5_flush_res" : "t5_rst_res", out_result, 0);
        end

        // repeated captures
        cap(8'h10, 4'h0);
        cap(8'h10, 4'h0);
        cap(8'h10, 4'h1);
        cap(8'h10, 4'h1);
        cap(8'h22, 4'h1);
        chk("t6_drop", drop_cnt, 0);
`ifdef ALU_TRACE_DEDUP_EN
        chk("t6_count", count, 3);
        mq = '{8'h10, 8'h10, 8'h22};
        begin
            logic [3:0] es [3] = '{4'h0, 4'h1, 4'h1};
            for (int i = 0; i < 3; i++) begin
                chk("t6_res", out_result, mq[i]);
                chk("t6_stat", out_stat, es[i]);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
`else
        chk("t6_count", count, 5);
        mq = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h22};
        begin
            logic [3:0] es [5] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
            for (int i = 0; i < 5; i++) begin
                chk("t6_res", out_result, mq[i]);
                chk("t6_stat", out_stat, es[i]);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
`endif
        chk("t6_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
